// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state definitions for the multi-cycle ALU.
// Also imported by the testbench so both sides use the same opcode names.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL1 = 4'h4;
    localparam logic [3:0] OP_SHR1 = 4'h5;
    localparam logic [3:0] OP_ROL1 = 4'h6;
    localparam logic [3:0] OP_ROR1 = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: WIDTH-step shift-add multiply or restoring divide.
// result/hi_nz show the value after the current step, valid when done is high.
module alu_iter_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hi_nz
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   sh, sum;
    logic             ge;

    // hi holds the partial product (MUL) or the partial remainder (DIV);
    // lo shifts out multiplier bits or shifts in quotient bits.
    always_comb begin
        sh   = {hi_q, lo_q[WIDTH-1]};
        ge   = (sh >= {1'b0, opd_q});
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        hi_n = hi_q;
        lo_n = lo_q;
        if (div_q) begin
            hi_n = ge ? (sh[WIDTH-1:0] - opd_q) : sh[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
        end else if (start) begin
            busy_q <= 1'b1;
            div_q  <= is_div;
            cnt_q  <= CNT_W'(WIDTH - 1);
            hi_q   <= '0;
            lo_q   <= a;
            opd_q  <= b;
        end else if (busy_q) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0)
                busy_q <= 1'b0;
        end
    end

    assign busy   = busy_q;
    assign done   = busy_q && (cnt_q == '0);
    assign result = lo_n;
    assign hi_nz  = ~div_q & (|hi_n);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready command handshake, single-cycle datapath,
// iterative MUL/DIV engine and registered result/flags held until accepted.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero,
    output logic             DivByZero
);
    localparam int M = WIDTH - 1;

    state_t           state, state_n;
    logic             ready_q;
    logic             accept, need_iter;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_dz;
    logic             eng_busy, eng_done, eng_hi_nz;
    logic [WIDTH-1:0] eng_res;

    assign accept    = in_valid & ready_q;
    assign need_iter = (ALU_Sel == OP_MUL) || ((ALU_Sel == OP_DIV) && (B != '0));
    assign in_ready  = ready_q;
    assign out_valid = (state == ST_DONE);

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (accept & need_iter),
        .is_div (ALU_Sel == OP_DIV),
        .a      (A),
        .b      (B),
        .busy   (eng_busy),
        .done   (eng_done),
        .result (eng_res),
        .hi_nz  (eng_hi_nz)
    );

    always_comb begin
        sum    = {1'b0, A} + {1'b0, B};
        diff   = {1'b0, A} - {1'b0, B};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_dz  = 1'b0;
        case (ALU_Sel)
            OP_SUB: begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
                sc_v   = (A[M] != B[M]) && (diff[M] != A[M]);
            end
            OP_MUL:  sc_res = '0;
            OP_DIV: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_SHL1: begin
                sc_res = {A[M-1:0], 1'b0};
                sc_c   = A[M];
            end
            OP_SHR1: begin
                sc_res = {1'b0, A[M:1]};
                sc_c   = A[0];
            end
            OP_ROL1: sc_res = {A[M-1:0], A[M]};
            OP_ROR1: sc_res = {A[0], A[M:1]};
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_NOR:  sc_res = ~(A | B);
            OP_NAND: sc_res = ~(A & B);
            OP_XNOR: sc_res = ~(A ^ B);
            OP_GT:   sc_res = {{(WIDTH-1){1'b0}}, (A > B)};
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, (A == B)};
            default: begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_v   = (A[M] == B[M]) && (sum[M] != A[M]);
            end
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = need_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (eng_done || !eng_busy) state_n = ST_DONE;
            ST_DONE: if (out_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // in_ready is registered so it stays low through reset and for the
    // handshake cycle itself, giving at most one op every two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q   <= 1'b0;
            ALU_Out   <= '0;
            CarryOut  <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            ready_q <= (state_n == ST_IDLE);
            if (accept && !need_iter) begin
                ALU_Out   <= sc_res;
                CarryOut  <= sc_c;
                Overflow  <= sc_v;
                Zero      <= (sc_res == '0);
                DivByZero <= sc_dz;
            end else if (eng_done) begin
                ALU_Out   <= eng_res;
                CarryOut  <= eng_hi_nz;
                Overflow  <= 1'b0;
                Zero      <= (eng_res == '0);
                DivByZero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc at WIDTH=8 and WIDTH=16 with an arithmetic
// reference model, per-instance expected-result queues and directed vectors.
module tb_alu_mc;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, ov8, or8 = 0, c8, v8, z8, dz8;
    logic [7:0]  a8 = 0, b8 = 0, y8;
    logic [3:0]  s8 = 0;
    logic        iv16 = 0, ir16, ov16, or16 = 0, c16, v16, z16, dz16;
    logic [15:0] a16 = 0, b16 = 0, y16;
    logic [3:0]  s16 = 0;

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .ALU_Sel(s8), .out_valid(ov8), .out_ready(or8), .ALU_Out(y8),
        .CarryOut(c8), .Overflow(v8), .Zero(z8), .DivByZero(dz8)
    );

    alu_mc #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .ALU_Sel(s16), .out_valid(ov16), .out_ready(or16), .ALU_Out(y16),
        .CarryOut(c16), .Overflow(v16), .Zero(z16), .DivByZero(dz16)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
        logic        z;
        logic        dz;
    } exp_t;

    typedef struct {
        bit          wide;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          c;
        bit          v;
        bit          dz;
        int          hold;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q8[$];
    exp_t q16[$];
    vec_t vecs[$];

    // Reference: plain integer arithmetic on the mathematical values.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        longint one = 1;
        longint ua = longint'(a), ub = longint'(b);
        longint m = (one << w) - 1;
        longint half = one << (w - 1);
        longint sa = (ua >= half) ? ua - (one << w) : ua;
        longint sb = (ub >= half) ? ub - (one << w) : ub;
        longint r = 0, sr = 0;
        exp_t e = '0;
        case (op)
            OP_ADD:  begin r = ua + ub; e.c = (r > m); sr = sa + sb; e.v = (sr >= half) || (sr < -half); end
            OP_SUB:  begin r = ua - ub; e.c = (ua < ub); sr = sa - sb; e.v = (sr >= half) || (sr < -half); end
            OP_MUL:  begin r = ua * ub; e.c = ((r >> w) != 0); end
            OP_DIV:  begin if (ub == 0) begin r = m; e.dz = 1'b1; end else r = ua / ub; end
            OP_SHL1: begin r = ua * 2; e.c = (ua >= half); end
            OP_SHR1: begin r = ua / 2; e.c = (ua % 2 == 1); end
            OP_ROL1: r = ua * 2 + ((ua >= half) ? 1 : 0);
            OP_ROR1: r = ua / 2 + ((ua % 2 == 1) ? half : 0);
            OP_AND:  r = ua & ub;
            OP_OR:   r = ua | ub;
            OP_XOR:  r = ua ^ ub;
            OP_NOR:  r = ~(ua | ub);
            OP_NAND: r = ~(ua & ub);
            OP_XNOR: r = ~(ua ^ ub);
            OP_GT:   r = (ua > ub) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        r = r & m;
        e.res = 32'(r);
        e.z = (r == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic cmp_out(input bit wide, input exp_t act);
        exp_t e;
        n_cmp++;
        if ((wide ? q16.size() : q8.size()) == 0) begin
            n_bad++;
            $display("FAIL out_spurious_w%0d: actual res=%h with no result expected", wide ? 16 : 8, act.res);
            return;
        end
        e = wide ? q16[0] : q8[0];
        if (act !== e) begin
            n_bad++;
            $display("FAIL out_w%0d: actual res=%h c=%b v=%b z=%b dz=%b required res=%h c=%b v=%b z=%b dz=%b",
                     wide ? 16 : 8, act.res, act.c, act.v, act.z, act.dz, e.res, e.c, e.v, e.z, e.dz);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (iv8 && ir8)   q8.push_back(model(8, s8, 32'(a8), 32'(b8)));
            if (iv16 && ir16) q16.push_back(model(16, s16, 32'(a16), 32'(b16)));
            if (ov8 && or8 && q8.size() > 0)    void'(q8.pop_front());
            if (ov16 && or16 && q16.size() > 0) void'(q16.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ov8)  cmp_out(1'b0, '{32'(y8), c8, v8, z8, dz8});
        if (ov16) cmp_out(1'b1, '{32'(y16), c16, v16, z16, dz16});
    end

    task automatic drive(input bit wide, input logic valid, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (wide) begin iv16 = valid; s16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        else      begin iv8  = valid; s8  = op; a8  = a[7:0];  b8  = b[7:0];  end
    endtask

    task automatic set_oready(input bit wide, input logic r);
        if (wide) or16 = r; else or8 = r;
    endtask

    function automatic logic rdy(input bit wide);
        return wide ? ir16 : ir8;
    endfunction

    function automatic logic vld(input bit wide);
        return wide ? ov16 : ov8;
    endfunction

    task automatic run_op(input vec_t t);
        int   w = t.wide ? 16 : 8;
        int   n;
        bit   iter = (t.op == OP_MUL) || (t.op == OP_DIV && t.b != 0);
        exp_t lit;
        lit = '{t.res, t.c, t.v, (t.res == 0), t.dz};
        chk($sformatf("model_pin_op%0h_w%0d", t.op, w), longint'(model(w, t.op, t.a, t.b)), longint'(lit));
        @(negedge clk);
        drive(t.wide, 1'b1, t.op, t.a, t.b);
        n = 0;
        while (!rdy(t.wide) && n < 50) begin @(negedge clk); n++; end
        chk("ready_before_accept", longint'(rdy(t.wide)), 1);
        @(posedge clk);
        #1 drive(t.wide, 1'b0, 4'($urandom), $urandom, $urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!vld(t.wide) && n < 200);
        chk($sformatf("latency_op%0h_w%0d", t.op, w), n, iter ? w + 1 : 1);
        if (!vld(t.wide)) return;
        for (int i = 0; i < t.hold; i++) begin
            drive(t.wide, 1'b1, OP_AND, 32'h0F, 32'h3C);
            chk("ready_low_in_done", longint'(rdy(t.wide)), 0);
            @(negedge clk);
        end
        drive(t.wide, 1'b0, OP_ADD, 0, 0);
        set_oready(t.wide, 1'b1);
        @(posedge clk);
        #1 set_oready(t.wide, 1'b0);
        @(negedge clk);
        chk("valid_drop_after_hs", longint'(vld(t.wide)), 0);
        chk("ready_after_hs", longint'(rdy(t.wide)), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             wide op       a            b            res          c  v  dz hold
        vecs.push_back('{0, OP_ADD,  32'hF6,      32'h0A,      32'h00,      1, 0, 0, 0});
        vecs.push_back('{0, OP_SUB,  32'h0A,      32'h02,      32'h08,      0, 0, 0, 0});
        vecs.push_back('{0, OP_SUB,  32'h02,      32'h0A,      32'hF8,      1, 0, 0, 0});
        vecs.push_back('{0, OP_MUL,  32'h0A,      32'h02,      32'h14,      0, 0, 0, 0});
        vecs.push_back('{0, OP_MUL,  32'h20,      32'h10,      32'h00,      1, 0, 0, 0});
        vecs.push_back('{0, OP_DIV,  32'hF6,      32'h0A,      32'h18,      0, 0, 0, 0});
        vecs.push_back('{0, OP_DIV,  32'h55,      32'h00,      32'hFF,      0, 0, 1, 0});
        vecs.push_back('{0, OP_ROL1, 32'h81,      32'h00,      32'h03,      0, 0, 0, 3});
        vecs.push_back('{0, OP_ADD,  32'h7F,      32'h01,      32'h80,      0, 1, 0, 0});
        vecs.push_back('{0, OP_SUB,  32'h80,      32'h01,      32'h7F,      0, 1, 0, 0});
        vecs.push_back('{0, OP_SHL1, 32'h81,      32'h00,      32'h02,      1, 0, 0, 0});
        vecs.push_back('{0, OP_SHR1, 32'h81,      32'h00,      32'h40,      1, 0, 0, 0});
        vecs.push_back('{0, OP_ROR1, 32'h81,      32'h00,      32'hC0,      0, 0, 0, 0});
        vecs.push_back('{0, OP_AND,  32'h5A,      32'h0F,      32'h0A,      0, 0, 0, 0});
        vecs.push_back('{0, OP_OR,   32'h5A,      32'h0F,      32'h5F,      0, 0, 0, 0});
        vecs.push_back('{0, OP_XOR,  32'h5A,      32'h0F,      32'h55,      0, 0, 0, 0});
        vecs.push_back('{0, OP_NOR,  32'h5A,      32'h0F,      32'hA0,      0, 0, 0, 0});
        vecs.push_back('{0, OP_NAND, 32'h5A,      32'h0F,      32'hF5,      0, 0, 0, 0});
        vecs.push_back('{0, OP_XNOR, 32'h5A,      32'h0F,      32'hAA,      0, 0, 0, 0});
        vecs.push_back('{0, OP_GT,   32'h05,      32'h03,      32'h01,      0, 0, 0, 0});
        vecs.push_back('{0, OP_GT,   32'h03,      32'h03,      32'h00,      0, 0, 0, 0});
        vecs.push_back('{0, OP_EQ,   32'h05,      32'h05,      32'h01,      0, 0, 0, 0});
        vecs.push_back('{0, OP_MUL,  32'hFF,      32'hFF,      32'h01,      1, 0, 0, 1});
        vecs.push_back('{0, OP_DIV,  32'h07,      32'h09,      32'h00,      0, 0, 0, 0});
        vecs.push_back('{0, OP_DIV,  32'hFF,      32'h01,      32'hFF,      0, 0, 0, 0});
        vecs.push_back('{1, OP_ADD,  32'hFFF6,    32'h000A,    32'h0000,    1, 0, 0, 0});
        vecs.push_back('{1, OP_SUB,  32'h0002,    32'h000A,    32'hFFF8,    1, 0, 0, 0});
        vecs.push_back('{1, OP_MUL,  32'h000A,    32'h0002,    32'h0014,    0, 0, 0, 0});
        vecs.push_back('{1, OP_MUL,  32'h0100,    32'h0100,    32'h0000,    1, 0, 0, 2});
        vecs.push_back('{1, OP_DIV,  32'hFFF6,    32'h000A,    32'h1998,    0, 0, 0, 0});
        vecs.push_back('{1, OP_DIV,  32'h0055,    32'h0000,    32'hFFFF,    0, 0, 1, 0});

        @(negedge clk);
        chk("rst_in_ready8", longint'(ir8), 0);
        chk("rst_out_valid8", longint'(ov8), 0);
        chk("rst_flags8", longint'({y8, c8, v8, z8, dz8}), 0);
        chk("rst_in_ready16", longint'(ir16), 0);
        chk("rst_outs16", longint'({ov16, y16, c16, v16, z16, dz16}), 0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset during the 4th BUSY cycle of a MUL: the result must never appear.
        @(negedge clk);
        drive(1'b0, 1'b1, OP_MUL, 32'h0A, 32'h02);
        for (int n = 0; n < 50 && !ir8; n++) @(negedge clk);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, OP_ADD, 0, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        q8.delete();
        q16.delete();
        @(negedge clk);
        chk("midmul_rst_ready", longint'(ir8), 0);
        chk("midmul_rst_outs", longint'({ov8, y8, c8, v8, z8, dz8}), 0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midmul_no_valid", longint'(ov8), 0);
        end
        chk("midmul_ready_after_release", longint'(ir8), 1);
        run_op('{0, OP_ADD, 32'h12, 32'h34, 32'h46, 0, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
